// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream helpers: lane slicing offsets and lane FIFO pointer sizing.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package hwpe_stream_package;

    localparam int unsigned BYTE_WIDTH = 8;

    // Bit offset of lane `lane` inside a wide bus made of `width`-bit lanes (lane 0 on LSBs).
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Lane FIFO pointer width: $clog2(depth), never narrower than one bit.
    function automatic int unsigned lane_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_split_lane_fifo.sv
// Per-lane FIFO for the decoupled stream splitter; DEPTH entries of data + strobe.
// Latency: a word pushed at edge N is visible on pop at cycle N+1.
// Backpressure: can_push_o = ~full | pop_rdy, so a full lane accepts a push while it pops.
// Ports: clk_i/rst_ni (sync, active-low)/clear_i; push_vld_i/push_dat_i/push_strb_i
//        (already qualified by the parent handshake); full_o, can_push_o;
//        pop_vld_o/pop_rdy_i/pop_dat_o/pop_strb_o.
// HWPE_STREAM_SPLIT_DECOUPLED_ASSERT_EN compiles in the occupancy bound check.
module hwpe_stream_split_lane_fifo
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             push_vld_i,
    input  logic [DATA_WIDTH-1:0]            push_dat_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] push_strb_i,
    output logic                             full_o,
    output logic                             can_push_o,
    output logic                             pop_vld_o,
    input  logic                             pop_rdy_i,
    output logic [DATA_WIDTH-1:0]            pop_dat_o,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0] pop_strb_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned PTR_WIDTH  = lane_ptr_width(DEPTH);
    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1);

    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    logic [DATA_WIDTH-1:0] dat_q  [DEPTH];
    logic [STRB_WIDTH-1:0] strb_q [DEPTH];
    ptr_t                  rd_ptr_q;
    ptr_t                  wr_ptr_q;
    cnt_t                  cnt_q;
    logic                  pop_hs;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign pop_vld_o  = (cnt_q != '0);
    assign pop_dat_o  = dat_q[rd_ptr_q];
    assign pop_strb_o = strb_q[rd_ptr_q];
    assign pop_hs     = pop_vld_o & pop_rdy_i;
    assign full_o     = (cnt_q == cnt_t'(DEPTH));
    // A full lane is always valid, so pop_rdy alone means it frees a slot this cycle.
    assign can_push_o = ~full_o | pop_rdy_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            // Storage is zeroed so the head reads back as 0 after reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dat_q[i]  <= '0;
                strb_q[i] <= '0;
            end
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_vld_i) begin
                dat_q[wr_ptr_q]  <= push_dat_i;
                strb_q[wr_ptr_q] <= push_strb_i;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (pop_hs) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push_vld_i && !pop_hs) begin
                cnt_q <= cnt_q + cnt_t'(1);
            end else if (!push_vld_i && pop_hs) begin
                cnt_q <= cnt_q - cnt_t'(1);
            end
        end
    end

`ifdef HWPE_STREAM_SPLIT_DECOUPLED_ASSERT_EN
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= cnt_t'(DEPTH))
        else $error("lane occupancy exceeds DEPTH");
`endif

endmodule

// File: rtl/hwpe_stream_split_decoupled.sv
// Splits one wide stream into NB_OUT_STREAMS narrow streams (lane 0 on LSBs), one FIFO per lane.
// Latency: push at edge N is visible on every lane at cycle N+1; no comb path push -> pop.
// Backpressure: push_rdy_o = rst_ni & ~clear_i & all lanes (not full | popping); all-or-nothing accept.
// Ports: clk_i, rst_ni (sync, active-low), clear_i; push_vld_i/push_rdy_o/push_dat_i/push_strb_i
//        (wide sink); pop_vld_o/pop_rdy_i/pop_dat_o/pop_strb_o (per-lane sources, packed lane 0 LSB).
// HWPE_STREAM_SPLIT_DECOUPLED_ASSERT_EN compiles in protocol and parameter checks.
module hwpe_stream_split_decoupled
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_OUT_STREAMS = 2,
    parameter int unsigned DATA_WIDTH_OUT = 8,
    parameter int unsigned LANE_DEPTH     = 2
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              clear_i,
    input  logic                                              push_vld_i,
    output logic                                              push_rdy_o,
    input  logic [DATA_WIDTH_OUT*NB_OUT_STREAMS-1:0]          push_dat_i,
    input  logic [DATA_WIDTH_OUT*NB_OUT_STREAMS/BYTE_WIDTH-1:0] push_strb_i,
    output logic [NB_OUT_STREAMS-1:0]                         pop_vld_o,
    input  logic [NB_OUT_STREAMS-1:0]                         pop_rdy_i,
    output logic [DATA_WIDTH_OUT*NB_OUT_STREAMS-1:0]          pop_dat_o,
    output logic [DATA_WIDTH_OUT*NB_OUT_STREAMS/BYTE_WIDTH-1:0] pop_strb_o
);

    localparam int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / BYTE_WIDTH;

    logic [NB_OUT_STREAMS-1:0] lane_full;
    logic [NB_OUT_STREAMS-1:0] lane_can_push;
    logic                      push_hs;
    logic                      unused_lane_full;

    assign push_rdy_o       = rst_ni & ~clear_i & (&lane_can_push);
    assign push_hs          = push_vld_i & push_rdy_o;
    assign unused_lane_full = &lane_full;

    for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_lane
        localparam int unsigned DLSB = lane_lsb(i, DATA_WIDTH_OUT);
        localparam int unsigned SLSB = lane_lsb(i, STRB_WIDTH_OUT);

        hwpe_stream_split_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH_OUT),
            .DEPTH      (LANE_DEPTH)
        ) u_lane_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (clear_i),
            .push_vld_i  (push_hs),
            .push_dat_i  (push_dat_i[DLSB +: DATA_WIDTH_OUT]),
            .push_strb_i (push_strb_i[SLSB +: STRB_WIDTH_OUT]),
            .full_o      (lane_full[i]),
            .can_push_o  (lane_can_push[i]),
            .pop_vld_o   (pop_vld_o[i]),
            .pop_rdy_i   (pop_rdy_i[i]),
            .pop_dat_o   (pop_dat_o[DLSB +: DATA_WIDTH_OUT]),
            .pop_strb_o  (pop_strb_o[SLSB +: STRB_WIDTH_OUT])
        );

`ifdef HWPE_STREAM_SPLIT_DECOUPLED_ASSERT_EN
        // A clear may legitimately drop a pending lane word.
        a_pop_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (pop_vld_o[i] && !pop_rdy_i[i] && !clear_i) |=>
            (pop_vld_o[i] && $stable(pop_dat_o[DLSB +: DATA_WIDTH_OUT])
                          && $stable(pop_strb_o[SLSB +: STRB_WIDTH_OUT])))
            else $error("pop lane %0d changed while stalled", i);

        a_full_blocks: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (lane_full[i] && !pop_rdy_i[i]) |-> !push_rdy_o)
            else $error("push accepted into full lane %0d", i);
`endif
    end

`ifdef HWPE_STREAM_SPLIT_DECOUPLED_ASSERT_EN
    if (NB_OUT_STREAMS < 2 || (DATA_WIDTH_OUT % 8) != 0 || DATA_WIDTH_OUT == 0 || LANE_DEPTH < 1)
    begin : g_param_err
        $error("illegal hwpe_stream_split_decoupled parameters");
    end

    a_push_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_vld_i && !push_rdy_o) |=>
        (push_vld_i && $stable(push_dat_i) && $stable(push_strb_i)))
        else $error("push stream changed while stalled");
`endif

endmodule
